// File: rtl/lag_readout_pkg.sv
// Shared constants and types for the lag correlator readout controller:
// register addresses, CTRL/STATUS bit positions and FSM state encoding.
package lag_readout_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_RESULT = 2'd2;
   localparam logic [1:0] ADDR_FRAMES = 2'd3;

   localparam int CTRL_ENABLE  = 0;
   localparam int CTRL_START   = 1;
   localparam int CTRL_CLR_ERR = 2;

   localparam int STAT_VALID   = 0;
   localparam int STAT_BUSY    = 1;
   localparam int STAT_TIMEOUT = 2;
   localparam int STAT_OVR_LSB = 8;
   localparam int OVR_BITS     = 8;

   typedef enum logic [1:0] {IDLE, ARM, WAIT} state_t;

   // One lag field must hold delays in [-max_lags, max_lags).
   function automatic int lag_bits(input int max_lags);
      return $clog2(2 * max_lags);
   endfunction

endpackage

// File: rtl/lag_readout_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/lag_readout_controller.sv
// Avalon-MM slave that starts the lag correlator, waits for its result strobe
// with a timeout, and latches the packed lags into a CPU-readable register.
//
// state | meaning
// IDLE  | no run in progress; waits for a start write or enable
// ARM   | corrStart high for this single cycle, timeout timer loaded
// WAIT  | waiting for lagsValid; timer counts down to the timeout
module lag_readout_controller
   import lag_readout_pkg::*;
#(
   parameter int NUM_SLAVES     = 4,
   parameter int MAX_LAGS       = 17,
   parameter int CPU_BITS       = 32,
   parameter int LAG_BITS       = lag_bits(MAX_LAGS),
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [1:0]                     address,
   input  logic                           read,
   input  logic                           write,
   input  logic [CPU_BITS-1:0]            writedata,
   output logic [CPU_BITS-1:0]            readdata,
   output logic                           corrStart,
   input  logic [NUM_SLAVES*LAG_BITS-1:0] lagsIn,
   input  logic                           lagsValid
);

   localparam int LANE_W = NUM_SLAVES * LAG_BITS;
   localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t                state, state_nxt;
   logic [TMR_W-1:0]      tmr;
   logic                  enable, timeout_flag, result_valid;
   logic [LANE_W-1:0]     result_lags;
   logic [CPU_BITS-1:0]   frames;
   logic [OVR_BITS-1:0]   ovr_cnt;
   logic [CPU_BITS-1:0]   rd_mux;
   logic                  wr_ctrl, start_req, clr_err, rd_result;
   logic                  capture, time_up, ovr_inc, busy;
   logic                  unused_wdata;

   assign wr_ctrl      = write && (address == ADDR_CTRL);
   assign start_req    = wr_ctrl && writedata[CTRL_START];
   assign clr_err      = wr_ctrl && writedata[CTRL_CLR_ERR];
   assign rd_result    = read && (address == ADDR_RESULT);
   assign busy         = (state != IDLE);
   assign unused_wdata = ^writedata[CPU_BITS-1:3];

   // A read racing a capture does not count as an overrun: the CPU saw the old word.
   assign ovr_inc = capture && result_valid && !rd_result;

   always_comb begin
      state_nxt = state;
      corrStart = 1'b0;
      capture   = 1'b0;
      time_up   = 1'b0;
      case (state)
         IDLE: if (start_req || enable) state_nxt = ARM;
         ARM: begin
            corrStart = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (lagsValid) begin
               capture   = 1'b1;
               state_nxt = enable ? ARM : IDLE;
            end else if (tmr == '0) begin
               time_up   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_CTRL:   rd_mux[CTRL_ENABLE] = enable;
         ADDR_STATUS: begin
            rd_mux[STAT_VALID]                   = result_valid;
            rd_mux[STAT_BUSY]                    = busy;
            rd_mux[STAT_TIMEOUT]                 = timeout_flag;
            rd_mux[STAT_OVR_LSB +: OVR_BITS]     = ovr_cnt;
         end
         ADDR_RESULT: begin
            rd_mux[CPU_BITS-1]   = result_valid;
            rd_mux[LANE_W-1:0]   = result_lags;
         end
         ADDR_FRAMES: rd_mux = frames;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         tmr          <= '0;
         enable       <= 1'b0;
         timeout_flag <= 1'b0;
         result_valid <= 1'b0;
         result_lags  <= '0;
         frames       <= '0;
         readdata     <= '0;
      end else begin
         state <= state_nxt;

         if (state == ARM)
            tmr <= TMR_LOAD;
         else if ((state == WAIT) && (tmr != '0))
            tmr <= tmr - TMR_W'(1);

         if (time_up)
            enable <= 1'b0;
         else if (wr_ctrl)
            enable <= writedata[CTRL_ENABLE];

         if (time_up)
            timeout_flag <= 1'b1;
         else if (clr_err)
            timeout_flag <= 1'b0;

         // Capture sets resultValid even when a RESULT read tries to clear it.
         if (capture) begin
            result_lags  <= lagsIn;
            result_valid <= 1'b1;
            frames       <= frames + CPU_BITS'(1);
         end else if (rd_result) begin
            result_valid <= 1'b0;
         end

         if (read)
            readdata <= rd_mux;
      end
   end

   sat_counter #(.W(OVR_BITS)) u_ovr_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ovr_inc),
      .clr   (clr_err),
      .count (ovr_cnt)
   );

endmodule

// File: tb/tb_lag_readout_controller.sv
// Randomised bench for lag_readout_controller against a transaction-level
// model of the capture, overrun, frame and timeout rules.
module tb_lag_readout_controller;
   import lag_readout_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        corrStart;
   logic [23:0] lagsIn = '0;
   logic        lagsValid = 1'b0;

   always #5 clk = ~clk;

   lag_readout_controller #(
      .NUM_SLAVES(4), .MAX_LAGS(17), .CPU_BITS(32), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata), .corrStart(corrStart),
      .lagsIn(lagsIn), .lagsValid(lagsValid)
   );

   int cyc = 0;
   int n_pulse = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (corrStart) n_pulse <= n_pulse + 1;
   end

   int n_checks = 0;
   int n_fail = 0;
   int exp_pulse = 0;

   // model state
   bit          m_rv = 0;
   logic [23:0] m_lags = '0;
   int          m_ovr = 0;
   int          m_frames = 0;
   bit          m_timeout = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic void m_capture(input logic [23:0] d, input bit rd_same);
      if (m_rv && !rd_same && m_ovr < 255) m_ovr++;
      m_rv = 1;
      m_lags = d;
      m_frames++;
   endfunction

   function automatic logic [31:0] m_status(input bit busy);
      return {16'd0, 8'(m_ovr), 5'd0, m_timeout, busy, m_rv};
   endfunction

   function automatic logic [31:0] m_result();
      return {m_rv, 7'd0, m_lags};
   endfunction

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address = a; read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      d = readdata;
   endtask

   task automatic rd_result_chk(input string tag);
      logic [31:0] got;
      bus_read(ADDR_RESULT, got);
      check(tag, got, m_result());
      m_rv = 0;
   endtask

   task automatic pulse_lags(input logic [23:0] d);
      lagsIn = d; lagsValid = 1'b1;
      @(negedge clk);
      lagsValid = 1'b0;
   endtask

   task automatic wait_corr(output int t);
      bit found = 0;
      t = -1;
      for (int i = 0; i < 64 && !found; i++) begin
         if (corrStart) begin
            t = cyc;
            found = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!found) check("corrstart_wait", 32'd0, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [23:0] d;
      int t, tm, exp_t, pc, n;
      bit bad;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         bus_read(2'(a), rd);
         check($sformatf("reset_read_%0d", a), rd, 32'd0);
      end
      check("reset_no_corrstart", 32'(n_pulse), 32'd0);

      // single shot
      tm = cyc;
      bus_write(ADDR_CTRL, 32'h2);
      exp_pulse++;
      wait_corr(t);
      check("start_latency", 32'(t - tm), 32'd1);
      repeat (5) @(negedge clk);
      pulse_lags(24'hABCDEF);
      m_capture(24'hABCDEF, 0);
      repeat (4) @(negedge clk);
      check("single_pulses", 32'(n_pulse), 32'(exp_pulse));
      rd_result_chk("single_result_first");
      rd_result_chk("single_result_second");
      bus_read(ADDR_FRAMES, rd);
      check("single_frames", rd, 32'(m_frames));
      bus_read(ADDR_STATUS, rd);
      check("single_status", rd, m_status(0));

      // continuous, random data/delays/reads, enable cleared during the last WAIT
      n = $urandom_range(3, 6);
      tm = cyc;
      bus_write(ADDR_CTRL, 32'h1);
      exp_t = tm + 2;
      for (int i = 0; i < n; i++) begin
         exp_pulse++;
         wait_corr(t);
         check("cont_corrstart_cycle", 32'(t), 32'(exp_t));
         if (i == n - 1) bus_write(ADDR_CTRL, 32'h0);
         else if ($urandom_range(0, 1) == 1) rd_result_chk("cont_result_read");
         else @(negedge clk);
         repeat ($urandom_range(0, 8)) @(negedge clk);
         d = 24'($urandom);
         pc = cyc;
         pulse_lags(d);
         m_capture(d, 0);
         exp_t = pc + 1;
      end
      repeat (10) @(negedge clk);
      check("cont_pulses", 32'(n_pulse), 32'(exp_pulse));
      bus_read(ADDR_STATUS, rd);
      check("cont_status", rd, m_status(0));
      bus_read(ADDR_FRAMES, rd);
      check("cont_frames", rd, 32'(m_frames));
      rd_result_chk("cont_result");
      bus_write(ADDR_CTRL, 32'h4);
      m_ovr = 0;
      bus_read(ADDR_STATUS, rd);
      check("clr_err_status", rd, m_status(0));

      // overrun saturation
      bus_write(ADDR_CTRL, 32'h1);
      exp_t = cyc + 1;
      bad = 0;
      for (int i = 0; i < 260; i++) begin
         exp_pulse++;
         wait_corr(t);
         if (t != exp_t) bad = 1;
         if (i == 259) bus_write(ADDR_CTRL, 32'h0);
         else @(negedge clk);
         d = 24'($urandom);
         pc = cyc;
         pulse_lags(d);
         m_capture(d, 0);
         exp_t = pc + 1;
      end
      check("sat_back_to_back", 32'(bad), 32'd0);
      repeat (4) @(negedge clk);
      bus_read(ADDR_STATUS, rd);
      check("sat_status", rd, m_status(0));
      bus_read(ADDR_FRAMES, rd);
      check("sat_frames", rd, 32'(m_frames));
      rd_result_chk("sat_result");
      bus_write(ADDR_CTRL, 32'h4);
      m_ovr = 0;

      // timeout, enable set
      bus_write(ADDR_CTRL, 32'h3);
      exp_pulse++;
      wait_corr(t);
      repeat (TO) @(negedge clk);
      bus_read(ADDR_STATUS, rd);
      check("timeout_last_wait_cycle", rd, m_status(1));
      m_timeout = 1;
      bus_read(ADDR_STATUS, rd);
      check("timeout_status", rd, m_status(0));
      bus_read(ADDR_CTRL, rd);
      check("timeout_enable_cleared", rd, 32'd0);
      pulse_lags(24'($urandom));
      repeat (3) @(negedge clk);
      bus_read(ADDR_FRAMES, rd);
      check("late_lags_frames", rd, 32'(m_frames));
      bus_read(ADDR_STATUS, rd);
      check("late_lags_status", rd, m_status(0));
      check("timeout_pulses", 32'(n_pulse), 32'(exp_pulse));

      // capture on the timeout cycle wins
      bus_write(ADDR_CTRL, 32'h4);
      m_timeout = 0;
      bus_write(ADDR_CTRL, 32'h2);
      exp_pulse++;
      wait_corr(t);
      repeat (TO) @(negedge clk);
      d = 24'($urandom);
      pulse_lags(d);
      m_capture(d, 0);
      bus_read(ADDR_STATUS, rd);
      check("edge_capture_status", rd, m_status(0));

      // RESULT read in the same cycle as a capture
      bus_write(ADDR_CTRL, 32'h2);
      exp_pulse++;
      wait_corr(t);
      repeat ($urandom_range(1, 10)) @(negedge clk);
      d = 24'($urandom);
      rd = m_result();
      address = ADDR_RESULT; read = 1'b1; lagsIn = d; lagsValid = 1'b1;
      @(negedge clk);
      read = 1'b0; lagsValid = 1'b0;
      check("same_cycle_old_word", readdata, rd);
      m_capture(d, 1);
      bus_read(ADDR_STATUS, rd);
      check("same_cycle_status", rd, m_status(0));
      rd_result_chk("same_cycle_new_word");

      // reset in the middle of WAIT
      bus_write(ADDR_CTRL, 32'h3);
      exp_pulse++;
      wait_corr(t);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_rv = 0; m_lags = '0; m_ovr = 0; m_frames = 0; m_timeout = 0;
      pulse_lags(24'($urandom));
      repeat (2) @(negedge clk);
      bus_read(ADDR_FRAMES, rd);
      check("reset_wait_frames", rd, 32'(m_frames));
      bus_read(ADDR_STATUS, rd);
      check("reset_wait_status", rd, m_status(0));
      rd_result_chk("reset_wait_result");
      repeat (20) @(negedge clk);
      check("total_pulses", 32'(n_pulse), 32'(exp_pulse));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
